uld_sequencer: RTL
==================

Name: uld_sequencer

Overview:
- Upstream of the DLA controller's layer-descriptor inputs.
- Host/CPU writes packed layer descriptors, 8 words each, into a small on-chip descriptor queue.
- On start, the block issues descriptors one at a time as a one-cycle uLD_en pulse with held field outputs. It waits for the controller's layer-done indication, then pops and issues the next descriptor.
- Raises an interrupt when the queue drains.

Parameters:
- DESC_DEPTH, 4: descriptor queue entries (power of 2, ≥2).
- WORDS_PER_DESC, 8: 32-bit words per descriptor (fixed encoding below).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_wvalid_i  in  1  host descriptor word valid
- cfg_wdata_i  in  32  host descriptor word
- cfg_wready_o  out  1  word accepted when valid&ready
- start_i  in  1  pulse: begin issuing queued descriptors
- abort_i  in  1  pulse: flush queue, return to IDLE
- layer_done_i  in  1  pulse from controller: current layer finished
- uLD_en_o  out  1  one-cycle descriptor-valid pulse
- layer_id_o 6, layer_type_o 2, in_R_o 8, in_C_o 8, in_D_o 11, out_K_o 11, stride_o 2, pad_T_o/pad_B_o/pad_L_o/pad_R_o 2 each, flags_o 4, quant_scale_o 8  out  descriptor fields
- base_ifmap_o, base_weight_o, base_bias_o, base_ofmap_o  out  32 each  DRAM bases
- busy_o  out  1  state ≠ IDLE/DONE
- q_count_o  out  $clog2(DESC_DEPTH)+1  committed descriptors in queue
- layers_done_o  out  16  layers completed since last start
- irq_o  out  1  run complete, sticky
- irq_clr_i  in  1  clears irq_o

Behaviour:
- Descriptor encoding:
  - W0: [5:0] id, [7:6] type, [15:8] in_R, [23:16] in_C, [25:24] stride, [29:26] flags
  - W1: [10:0] in_D, [21:11] out_K, [29:22] quant
  - W2: [1:0] pad_T, [3:2] pad_B, [5:4] pad_L, [7:6] pad_R
  - W3–W6: ifmap, weight, bias, ofmap bases
  - W7: ignored
  - Unused bits ignored.
- Write side:
  - A 3-bit word index increments on each accepted word.
  - The descriptor is assembled in a staging register and committed to the queue tail on W7 acceptance; the index then wraps to 0.
  - cfg_wready_o = (q_count < DESC_DEPTH) && state ≠ ABORT-cycle. It stays low for the whole staging when the queue is full, so a partial descriptor never commits.
- Queue: circular, write/read pointers. Commit and pop in the same cycle leave the count unchanged. Count saturates never (guarded by ready).
- FSM states:
  - IDLE: start_i with q_count>0 → ISSUE. start_i with q_count==0 → DONE (irq set, layers_done=0). start_i clears layers_done_o.
  - ISSUE: load head entry into output field registers; uLD_en_o=1 this cycle only → WAIT.
  - WAIT: on layer_done_i, pop head and increment layers_done_o. If the queue is empty after the pop (same-cycle commit counts) → DONE, else → ISSUE.
  - DONE: irq_o set on entry; → IDLE the next cycle. irq_o stays set until irq_clr_i; a clear and a set in the same cycle resolve to set.
- Latency: start_i at cycle t → uLD_en_o at t+1. layer_done_i at t → next uLD_en_o at t+1.
- Field outputs stay stable from the ISSUE cycle until the next ISSUE, as the controller samples only on uLD_en.
- layer_done_i outside WAIT: ignored. start_i outside IDLE: ignored.
- abort_i (any state, priority over all): pointers, count and word index reset; state → IDLE; irq unchanged; no uLD_en that cycle.
- Reset values: every output 0, except cfg_wready_o=1 after reset deassertion. State IDLE, pointers/index 0.
- layers_done_o wraps at 16 bits.

Test Plan:
- Reset, then write one descriptor (W0=0x0C_3838_41: id=1, type=1, in_R=in_C=0x38…), start_i → uLD_en_o high exactly 1 cycle at t+1 with decoded fields. layer_done_i → irq_o=1, layers_done_o=1, busy_o=0.
- Fill 4 descriptors → q_count_o=4, cfg_wready_o=0. A 5th word is stalled until the first pop, then accepted; 5 layers issued in order with the correct ids.
- Word 7 commit in the same cycle as a WAIT pop → q_count_o unchanged, next ISSUE uses the correct head.
- layer_done_i pulsed in IDLE and in ISSUE → no pop, no count change.
- abort_i mid-WAIT with 3 queued and a half-written descriptor → q_count_o=0, next written descriptor starts at W0, no uLD_en pulse.
- start_i with an empty queue → irq_o=1 in 1 cycle, no uLD_en. irq_clr_i → irq_o=0. Async rst_n low mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/uld_sequencer.sv
// uld_sequencer: accepts packed layer descriptors from a host write port,
// queues them, and issues them one at a time to the DLA controller as a
// one-cycle uLD_en pulse with held field outputs. The next descriptor is
// issued after the controller reports layer-done. An interrupt is raised
// when the queue drains.
module uld_sequencer #(
  parameter int DESC_DEPTH     = 4,
  parameter int WORDS_PER_DESC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wvalid_i,
  input  logic [31:0] cfg_wdata_i,
  output logic        cfg_wready_o,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        layer_done_i,
  output logic        uLD_en_o,
  output logic [5:0]  layer_id_o,
  output logic [1:0]  layer_type_o,
  output logic [7:0]  in_R_o,
  output logic [7:0]  in_C_o,
  output logic [10:0] in_D_o,
  output logic [10:0] out_K_o,
  output logic [1:0]  stride_o,
  output logic [1:0]  pad_T_o,
  output logic [1:0]  pad_B_o,
  output logic [1:0]  pad_L_o,
  output logic [1:0]  pad_R_o,
  output logic [3:0]  flags_o,
  output logic [7:0]  quant_scale_o,
  output logic [31:0] base_ifmap_o,
  output logic [31:0] base_weight_o,
  output logic [31:0] base_bias_o,
  output logic [31:0] base_ofmap_o,
  output logic        busy_o,
  output logic [$clog2(DESC_DEPTH):0] q_count_o,
  output logic [15:0] layers_done_o,
  output logic        irq_o,
  input  logic        irq_clr_i
);

  localparam int PTR_W = $clog2(DESC_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(WORDS_PER_DESC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [5:0]  id;
    logic [1:0]  ltype;
    logic [7:0]  in_r;
    logic [7:0]  in_c;
    logic [1:0]  stride;
    logic [3:0]  flags;
    logic [10:0] in_d;
    logic [10:0] out_k;
    logic [7:0]  quant;
    logic [7:0]  pads;      // {pad_R, pad_L, pad_B, pad_T}
    logic [31:0] b_ifmap;
    logic [31:0] b_weight;
    logic [31:0] b_bias;
    logic [31:0] b_ofmap;
  } desc_t;

  logic [1:0]       r_state, w_state_next;
  logic [PTR_W-1:0] r_wptr, r_rptr, w_issue_ptr;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic [IDX_W-1:0] r_widx;
  logic [15:0]      r_layers_done;
  logic             r_irq;
  desc_t            r_stage, r_out, w_head;
  desc_t            r_q [DESC_DEPTH];

  logic w_wready, w_accept, w_commit, w_pop, w_start, w_load;

  // Ready drops while the queue is full and during an abort cycle; it is
  // also held low while reset is asserted so every output reads 0 then.
  assign w_wready = rst_n && !abort_i && (r_count < CNT_W'(DESC_DEPTH));
  assign w_accept = cfg_wvalid_i && w_wready;
  assign w_commit = w_accept && (r_widx == IDX_W'(WORDS_PER_DESC - 1));
  assign w_pop    = (r_state == S_WAIT) && layer_done_i && !abort_i;
  assign w_start  = (r_state == S_IDLE) && start_i && !abort_i;

  assign w_count_next = r_count + CNT_W'(w_commit) - CNT_W'(w_pop);
  assign w_issue_ptr  = r_rptr + PTR_W'(w_pop);

  // A descriptor committed in the same cycle as the pop that exposes it has
  // not reached the queue array yet, so take it straight from staging.
  assign w_head = (w_commit && (r_wptr == w_issue_ptr)) ? r_stage : r_q[w_issue_ptr];

  // Next-state decode; abort overrides every state.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_state_next = r_state;
    if (abort_i) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start_i) w_state_next = (r_count != '0) ? S_ISSUE : S_DONE;
        S_ISSUE: w_state_next = S_WAIT;
        S_WAIT:  if (layer_done_i) w_state_next = (w_count_next == '0) ? S_DONE : S_ISSUE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // ISSUE is never held, so entering it is exactly when fields must load.
  assign w_load = (w_state_next == S_ISSUE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Queue pointers, occupancy and host word index; abort flushes all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_widx  <= '0;
    end else if (abort_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_widx  <= '0;
    end else begin
      if (w_accept) r_widx <= r_widx + IDX_W'(1);
      if (w_commit) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)    r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  // Descriptor queue storage.
  always_ff @(posedge clk) begin
    // NOTE: queue array has no reset; entries are only read once the count says they are valid.
    if (w_commit) r_q[r_wptr] <= r_stage;
  end

  // Staging register: decode each accepted word into its descriptor fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (w_accept) begin
      case (r_widx)
        3'd0: begin
          r_stage.id     <= cfg_wdata_i[5:0];
          r_stage.ltype  <= cfg_wdata_i[7:6];
          r_stage.in_r   <= cfg_wdata_i[15:8];
          r_stage.in_c   <= cfg_wdata_i[23:16];
          r_stage.stride <= cfg_wdata_i[25:24];
          r_stage.flags  <= cfg_wdata_i[29:26];
        end
        3'd1: begin
          r_stage.in_d  <= cfg_wdata_i[10:0];
          r_stage.out_k <= cfg_wdata_i[21:11];
          r_stage.quant <= cfg_wdata_i[29:22];
        end
        3'd2: r_stage.pads     <= cfg_wdata_i[7:0];
        3'd3: r_stage.b_ifmap  <= cfg_wdata_i;
        3'd4: r_stage.b_weight <= cfg_wdata_i;
        3'd5: r_stage.b_bias   <= cfg_wdata_i;
        3'd6: r_stage.b_ofmap  <= cfg_wdata_i;
        default: ;
      endcase
    end
  end

  // Held field outputs: refreshed only on entry to ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_out <= '0;
    else if (w_load) r_out <= w_head;
  end

  // Completed-layer counter: cleared by an accepted start, wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_layers_done <= '0;
    else if (w_start) r_layers_done <= '0;
    else if (w_pop)   r_layers_done <= r_layers_done + 16'd1;
  end

  // Sticky interrupt: set on DONE entry, set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_irq <= 1'b0;
    else if (w_state_next == S_DONE) r_irq <= 1'b1;
    else if (irq_clr_i)              r_irq <= 1'b0;
  end

  assign cfg_wready_o  = w_wready;
  assign uLD_en_o      = (r_state == S_ISSUE) && !abort_i;
  assign busy_o        = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign q_count_o     = r_count;
  assign layers_done_o = r_layers_done;
  assign irq_o         = r_irq;

  assign layer_id_o    = r_out.id;
  assign layer_type_o  = r_out.ltype;
  assign in_R_o        = r_out.in_r;
  assign in_C_o        = r_out.in_c;
  assign in_D_o        = r_out.in_d;
  assign out_K_o       = r_out.out_k;
  assign stride_o      = r_out.stride;
  assign flags_o       = r_out.flags;
  assign quant_scale_o = r_out.quant;
  assign pad_T_o       = r_out.pads[1:0];
  assign pad_B_o       = r_out.pads[3:2];
  assign pad_L_o       = r_out.pads[5:4];
  assign pad_R_o       = r_out.pads[7:6];
  assign base_ifmap_o  = r_out.b_ifmap;
  assign base_weight_o = r_out.b_weight;
  assign base_bias_o   = r_out.b_bias;
  assign base_ofmap_o  = r_out.b_ofmap;

endmodule
